// File: rtl/mem_model_core_if.sv
// Request/response bundle between the mem_interface driver and mem_model_core.
// The master issues wr/rd/addr/wdata; the slave returns rdata/response/err.
interface mem_model_core_if #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 32
) ();
   logic                  wr;
   logic                  rd;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  response;
   logic                  err;

   modport master (
      output wr, rd, addr, wdata,
      input  rdata, response, err
   );

   modport slave (
      input  wr, rd, addr, wdata,
      output rdata, response, err
   );
endinterface

// File: rtl/mem_model_core.sv
// Single-port memory model: one request per cycle, fixed-latency response
// pipeline, side-band err for illegal requests.
module mem_model_core #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 256,
   parameter int unsigned LATENCY    = 2
) (
   input  logic             clk,
   input  logic             rst,
   mem_model_core_if.slave  bus
);

   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

   typedef struct packed {
      logic                  valid;
      logic                  is_read;
      logic                  is_err;
      logic [DATA_WIDTH-1:0] data;
   } stage_t;

   logic [DATA_WIDTH-1:0] mem_q   [DEPTH];
   stage_t                stage_q [LATENCY];
   stage_t                stage_d [LATENCY];

   logic req;
   logic in_range;
   logic illegal;
   logic wr_ok;
   logic rd_ok;

   always_comb begin
      req      = bus.wr | bus.rd;
      // Extra MSB keeps the compare correct when DEPTH == 2**ADDR_WIDTH.
      in_range = ({1'b0, bus.addr} < DEPTH_W);
      illegal  = req & ((bus.wr & bus.rd) | ~in_range);
      wr_ok    = bus.wr & ~bus.rd & in_range;
      rd_ok    = bus.rd & ~bus.wr & in_range;

      stage_d[0].valid   = req;
      stage_d[0].is_read = rd_ok;
      stage_d[0].is_err  = illegal;
      stage_d[0].data    = rd_ok ? mem_q[bus.addr] : '0;
      for (int unsigned i = 1; i < LATENCY; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         for (int unsigned i = 0; i < LATENCY; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < LATENCY; i++) begin
            stage_q[i] <= stage_d[i];
         end
         if (wr_ok) begin
            mem_q[bus.addr] <= bus.wdata;
         end
      end
   end

   always_comb begin
      bus.response = stage_q[LATENCY-1].valid;
      bus.err      = stage_q[LATENCY-1].valid & stage_q[LATENCY-1].is_err;
      bus.rdata    = (stage_q[LATENCY-1].valid & stage_q[LATENCY-1].is_read &
                      ~stage_q[LATENCY-1].is_err) ? stage_q[LATENCY-1].data : '0;
   end

endmodule

// File: tb/tb_mem_model_core.sv
// Scoreboard bench driving three mem_model_core instances (LATENCY 1, 2, 4;
// DEPTH 200) with one shared directed request stream.
module tb_mem_model_core;

   localparam int unsigned AW  = 8;
   localparam int unsigned DW  = 32;
   localparam int unsigned DEP = 200;

   typedef struct {
      logic          resp;
      logic          err;
      logic [DW-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   mem_model_core_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if1 ();
   mem_model_core_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if2 ();
   mem_model_core_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if4 ();

   mem_model_core #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP), .LATENCY(1)) u_l1 (
      .clk (clk), .rst (rst), .bus (if1.slave));
   mem_model_core #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP), .LATENCY(2)) u_l2 (
      .clk (clk), .rst (rst), .bus (if2.slave));
   mem_model_core #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP), .LATENCY(4)) u_l4 (
      .clk (clk), .rst (rst), .bus (if4.slave));

   always #5 clk = ~clk;

   int unsigned   n_vec  = 0;
   int unsigned   n_fail = 0;
   logic [DW-1:0] mdl [256];
   exp_t          q1 [$];
   exp_t          q2 [$];
   exp_t          q4 [$];

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic resp, input logic err,
                          input logic [DW-1:0] rdata, input exp_t e);
      chk({tag, ".response"}, DW'(resp), DW'(e.resp));
      chk({tag, ".err"},      DW'(err),  DW'(e.err));
      chk({tag, ".rdata"},    rdata,     e.data);
   endtask

   function automatic exp_t model(input logic w, input logic r, input logic [AW-1:0] a,
                                  input logic [DW-1:0] d);
      exp_t e;
      e.resp = w | r;
      e.err  = 1'b0;
      e.data = '0;
      if (w | r) begin
         if ((w & r) || (int'(a) >= int'(DEP))) begin
            e.err = 1'b1;
         end else if (w) begin
            mdl[a] = d;
         end else begin
            e.data = mdl[a];
         end
      end
      return e;
   endfunction

   task automatic drive(input logic w, input logic r, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
      if1.wr = w; if1.rd = r; if1.addr = a; if1.wdata = d;
      if2.wr = w; if2.rd = r; if2.addr = a; if2.wdata = d;
      if4.wr = w; if4.rd = r; if4.addr = a; if4.wdata = d;
   endtask

   task automatic step(input logic w, input logic r, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
      exp_t e;
      drive(w, r, a, d);
      e = model(w, r, a, d);
      q1.push_back(e);
      q2.push_back(e);
      q4.push_back(e);
      @(posedge clk);
      #1;
      if (q1.size() >= 1) chk_out("L1", if1.response, if1.err, if1.rdata, q1.pop_front());
      if (q2.size() >= 2) chk_out("L2", if2.response, if2.err, if2.rdata, q2.pop_front());
      if (q4.size() >= 4) chk_out("L4", if4.response, if4.err, if4.rdata, q4.pop_front());
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0);
   endtask

   task automatic do_reset();
      exp_t z;
      z.resp = 1'b0;
      z.err  = 1'b0;
      z.data = '0;
      rst = 1'b1;
      drive(1'b1, 1'b0, 8'h05, 32'hFFFF_FFFF);
      @(posedge clk);
      #1;
      chk_out("RST.L1", if1.response, if1.err, if1.rdata, z);
      chk_out("RST.L2", if2.response, if2.err, if2.rdata, z);
      chk_out("RST.L4", if4.response, if4.err, if4.rdata, z);
      rst = 1'b0;
      q1.delete();
      q2.delete();
      q4.delete();
      for (int i = 0; i < 256; i++) mdl[i] = '0;
      q2.push_back(z);
      for (int i = 0; i < 3; i++) q4.push_back(z);
   endtask

   initial begin
      drive(1'b0, 1'b0, '0, '0);
      do_reset();

      // Read after reset returns zero
      step(1'b0, 1'b1, 8'h10, 32'h0BAD_F00D);
      idle(4);

      // Write then read same address on consecutive edges
      step(1'b1, 1'b0, 8'h05, 32'hDEAD_BEEF);
      step(1'b0, 1'b1, 8'h05, 32'h0);
      idle(4);

      // Back-to-back writes then reads
      step(1'b1, 1'b0, 8'h00, 32'h11);
      step(1'b1, 1'b0, 8'h01, 32'h22);
      step(1'b1, 1'b0, 8'h02, 32'h33);
      step(1'b1, 1'b0, 8'h03, 32'h44);
      step(1'b0, 1'b1, 8'h00, 32'hFFFF_FFFF);
      step(1'b0, 1'b1, 8'h01, 32'h0);
      step(1'b0, 1'b1, 8'h02, 32'h0);
      step(1'b0, 1'b1, 8'h03, 32'h0);
      idle(4);

      // Read then write same address: read sees old data
      step(1'b0, 1'b1, 8'h02, 32'h0);
      step(1'b1, 1'b0, 8'h02, 32'h99);
      step(1'b0, 1'b1, 8'h02, 32'h0);

      // Illegal requests and address boundary
      step(1'b1, 1'b0, 8'h07, 32'hA5);
      step(1'b1, 1'b1, 8'h07, 32'h1234_5678);
      step(1'b0, 1'b1, 8'hFF, 32'h0);
      step(1'b1, 1'b0, 8'hC7, 32'h0000_C7C7);
      step(1'b0, 1'b1, 8'hC7, 32'h0);
      step(1'b1, 1'b0, 8'hC8, 32'h5555_5555);
      step(1'b0, 1'b1, 8'h07, 32'h0);
      idle(4);

      // Reset with reads in flight
      step(1'b0, 1'b1, 8'h05, 32'h0);
      step(1'b0, 1'b1, 8'h05, 32'h0);
      do_reset();
      idle(4);
      step(1'b0, 1'b1, 8'h05, 32'h0);
      idle(4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
